// File: rtl/stoch_scale_sched.sv
// Round-robin share of one stochastic scaler: CLEAR, EPOCH-cycle RUN, DRAIN, then REPORT a ones count.
// Latency REQ->DONE is EPOCH+3 cycles; no backpressure, a requester dropping REQ aborts its grant.
module stoch_scale_sched #(
  parameter int NREQ  = 4,
  parameter int EPOCH = 256,
  parameter int CW    = 9,
  parameter int IDW   = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] BITS_IN,
  output logic [NREQ-1:0] GNT,
  output logic            SC_IN,
  output logic            SC_CLR,
  input  logic            SC_OUT,
  output logic            DONE,
  output logic [IDW-1:0]  DONE_ID,
  output logic [CW-1:0]   COUNT,
  output logic            BUSY
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, REPORT} state_t;

  localparam logic [CW-1:0]  BC_LAST = CW'(EPOCH - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);

  state_t          state, state_n;
  logic [IDW-1:0]  ptr, gid, gid_n, gid_inc, win;
  logic [IDW:0]    idx;
  logic            win_vld, abort, active;
  logic [CW-1:0]   bc, acc;
  logic [NREQ-1:0] gnt_n;

  // Nearest set request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (IDW+1)'(i);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!win_vld && REQ[idx[IDW-1:0]]) begin
        win     = idx[IDW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  assign gid_inc = (gid == ID_LAST) ? '0 : gid + IDW'(1);
  assign active  = (state == CLEAR) || (state == RUN) || (state == DRAIN);
  assign abort   = active && !REQ[gid];

  always_comb begin
    state_n = state;
    SC_IN   = 1'b0;
    SC_CLR  = 1'b0;
    DONE    = 1'b0;
    BUSY    = (state != IDLE);
    gid_n   = (state == IDLE) ? win : gid;
    gnt_n   = '0;
    case (state)
      IDLE:   if (win_vld) state_n = CLEAR;
      CLEAR: begin
        SC_CLR  = 1'b1;
        state_n = abort ? IDLE : RUN;
      end
      RUN: begin
        SC_IN = BITS_IN[gid];
        if (abort)              state_n = IDLE;
        else if (bc == BC_LAST) state_n = DRAIN;
      end
      DRAIN:  state_n = abort ? IDLE : REPORT;
      REPORT: begin
        DONE    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == CLEAR || state_n == RUN || state_n == DRAIN) gnt_n[gid_n] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= '0;
      gid     <= '0;
      GNT     <= '0;
      bc      <= '0;
      acc     <= '0;
      COUNT   <= '0;
      DONE_ID <= '0;
    end else begin
      state <= state_n;
      GNT   <= gnt_n;
      case (state)
        IDLE: if (win_vld) gid <= win;
        CLEAR: begin
          bc  <= '0;
          acc <= '0;
        end
        RUN: begin
          bc <= bc + CW'(1);
          // Output sample at bc=0 still reflects the cleared memory, not stream bit 0.
          if (bc != '0 && SC_OUT) acc <= acc + CW'(1);
        end
        DRAIN: begin
          acc <= acc + CW'(SC_OUT);
          if (!abort) begin
            COUNT   <= acc + CW'(SC_OUT);
            DONE_ID <= gid;
          end
        end
        REPORT: ptr <= gid_inc;
        default: ;
      endcase
      if (abort) ptr <= gid_inc;
    end
  end

endmodule

// File: tb/tb_stoch_scale_sched.sv
// Bench for stoch_scale_sched: behavioural scaler, round-robin model and ones-count scoreboard.
module tb_stoch_scale_sched;
  localparam int NREQ = 4, EPOCH = 256, CW = 9, IDW = 2;

  logic            CLK = 1'b0, RST = 1'b1;
  logic [NREQ-1:0] REQ = '0, BITS_IN = '0, GNT;
  logic            SC_IN, SC_CLR, SC_OUT = 1'b0, DONE, BUSY;
  logic [IDW-1:0]  DONE_ID;
  logic [CW-1:0]   COUNT;

  stoch_scale_sched #(.NREQ(NREQ), .EPOCH(EPOCH), .CW(CW), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .BITS_IN(BITS_IN), .GNT(GNT),
    .SC_IN(SC_IN), .SC_CLR(SC_CLR), .SC_OUT(SC_OUT), .DONE(DONE),
    .DONE_ID(DONE_ID), .COUNT(COUNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // Scaler model: one-clock registered pass-through, optionally stretching each 1 over 2 clocks.
  bit   stretch = 1'b0;
  logic sc_d1 = 1'b0;
  always @(posedge CLK) begin
    if (SC_CLR) begin
      SC_OUT <= 1'b0;
      sc_d1  <= 1'b0;
    end else begin
      SC_OUT <= stretch ? (SC_IN | sc_d1) : SC_IN;
      sc_d1  <= SC_IN;
    end
  end

  // Stream source: bit k of each requester's vector is presented in RUN cycle k.
  logic [EPOCH-1:0] vec [NREQ];
  int k = EPOCH;
  always @(posedge CLK) begin
    #1;
    if (SC_CLR) begin
      k = 0;
      BITS_IN = '0;
    end else if (k < EPOCH) begin
      for (int i = 0; i < NREQ; i++) BITS_IN[i] = vec[i][k];
      k++;
    end else begin
      BITS_IN = '0;
    end
  end

  typedef struct { int id; int cnt; } exp_t;
  exp_t sb[$];
  int last_id = 0, last_cnt = 0;
  int gnt_total = 0, clr_total = 0, viol = 0, done_cyc = 0, clr_gap = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (GNT != '0) gnt_total++;
    if (SC_CLR) begin
      clr_total++;
      clr_gap = cyc - done_cyc;
    end
    if ($countones(GNT) > 1 || (GNT == '0 && (SC_IN || SC_CLR)) || (SC_CLR && SC_IN) ||
        (DONE && GNT != '0) || (!BUSY && (GNT != '0 || DONE)))
      viol++;
    if (DONE) begin
      done_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done id=%0d count=%0d with nothing expected", DONE_ID, COUNT);
      end else begin
        e = sb.pop_front();
        check("done_id", int'(DONE_ID), e.id);
        check("count", int'(COUNT), e.cnt);
        last_id  = e.id;
        last_cnt = e.cnt;
      end
    end
  end

  // Reference model: round-robin pointer and per-epoch ones count.
  int mptr = 0;

  function automatic int predict(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++)
      if (r[(mptr + i) % NREQ]) return (mptr + i) % NREQ;
    return 0;
  endfunction

  function automatic int ref_count(input logic [EPOCH-1:0] v, input bit st);
    int s = 0;
    for (int j = 0; j < EPOCH; j++) begin
      if (v[j]) s++;
      else if (st && j > 0) begin
        if (v[j-1]) s++;
      end
    end
    return s;
  endfunction

  task automatic issue(input logic [NREQ-1:0] r, output int id);
    exp_t e;
    REQ   = r;
    id    = predict(r);
    e.id  = id;
    e.cnt = ref_count(vec[id], stretch);
    sb.push_back(e);
    mptr = (id + 1) % NREQ;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= EPOCH * 4; n++) begin
      @(negedge CLK);
      if (DONE) begin
        lat = n;
        return;
      end
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic wait_clr();
    for (int n = 1; n <= 16; n++) begin
      @(negedge CLK);
      if (SC_CLR) return;
    end
    check("clr_timeout", 0, 1);
  endtask

  task automatic randomize_vecs();
    for (int i = 0; i < NREQ; i++)
      for (int w = 0; w < EPOCH / 32; w++) vec[i][w*32 +: 32] = $urandom();
  endtask

  task automatic run_one(input logic [NREQ-1:0] r, output int lat);
    int id;
    @(posedge CLK); #1;
    issue(r, id);
    wait_done(lat);
    @(posedge CLK); #1;
    REQ = '0;
  endtask

  initial begin
    int lat, id, g0, c0;
    randomize_vecs();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_gnt", int'(GNT), 0);
    check("rst_sc_in", int'(SC_IN), 0);
    check("rst_sc_clr", int'(SC_CLR), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_done_id", int'(DONE_ID), 0);
    check("rst_count", int'(COUNT), 0);
    check("rst_busy", int'(BUSY), 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Round robin with all requests held.
    @(posedge CLK); #1;
    issue('1, id);
    for (int e = 0; e < 8; e++) begin
      wait_done(lat);
      check("rr_seq", int'(DONE_ID), e % NREQ);
      if (e > 0) check("rr_gap", clr_gap, 2);
      if (e < 7) issue('1, id);
    end
    @(posedge CLK); #1;
    REQ = '0;

    // Single constant-one stream: occupancy and latency.
    vec[0] = '1;
    g0 = gnt_total;
    c0 = clr_total;
    run_one(4'b0001, lat);
    check("single_latency", lat, EPOCH + 4);
    check("single_gnt_cycles", gnt_total - g0, EPOCH + 2);
    check("single_clr_pulses", clr_total - c0, 1);
    check("single_count", int'(COUNT), EPOCH);

    // Zero stream on requester 2, then pointer must sit at 3.
    vec[2] = '0;
    run_one(4'b0100, lat);
    check("zero_count", int'(COUNT), 0);
    randomize_vecs();
    run_one(4'b1001, lat);
    check("ptr_after_zero", int'(DONE_ID), 3);

    // Known density, pass-through then stretching scaler.
    for (int j = 0; j < EPOCH; j++) vec[1][j] = (j % 2 == 0);
    run_one(4'b0010, lat);
    check("density_half", int'(COUNT), EPOCH / 2);
    stretch = 1'b1;
    run_one(4'b0010, lat);
    stretch = 1'b0;

    // Abort requester 0 in RUN cycle 100; requester 1 should win next.
    randomize_vecs();
    @(posedge CLK); #1;
    REQ = 4'b0011;
    wait_clr();
    check("abort_gnt", int'(GNT), 1);
    repeat (101) @(posedge CLK);
    #1;
    REQ = 4'b0110;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_gnt_off", int'(GNT), 0);
    check("abort_busy", int'(BUSY), 0);
    check("abort_count_held", int'(COUNT), last_cnt);
    check("abort_id_held", int'(DONE_ID), last_id);
    mptr = 1;
    issue(4'b0110, id);
    wait_done(lat);
    check("abort_next_id", int'(DONE_ID), 1);
    @(posedge CLK); #1;
    REQ = '0;

    // Reset in RUN cycle 50; pointer returns to 0 so requester 1 beats 3.
    @(posedge CLK); #1;
    REQ = 4'b1010;
    wait_clr();
    check("rst_run_gnt", int'(GNT), 4'b1000);
    repeat (51) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_run_gnt_off", int'(GNT), 0);
    check("rst_run_done", int'(DONE), 0);
    check("rst_run_count", int'(COUNT), 0);
    check("rst_run_done_id", int'(DONE_ID), 0);
    check("rst_run_busy", int'(BUSY), 0);
    check("rst_run_sc_clr", int'(SC_CLR), 0);
    mptr = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    issue(4'b1010, id);
    wait_done(lat);
    check("rst_next_id", int'(DONE_ID), 1);
    @(posedge CLK); #1;
    REQ = '0;

    // Random requests, streams and scaler modes.
    for (int t = 0; t < 6; t++) begin
      randomize_vecs();
      stretch = bit'($urandom_range(0, 1));
      run_one(NREQ'($urandom_range(1, (1 << NREQ) - 1)), lat);
      check("rand_latency", lat, EPOCH + 4);
    end

    repeat (4) @(negedge CLK);
    check("protocol_violations", viol, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
